// File: rtl/imem_byte_loader.sv
// imem_byte_loader: receives a framed byte stream (16-bit word count,
// little-endian instruction words, XOR checksum) and writes the words into
// the instruction memory. The core is held in reset until a frame loads
// cleanly.
module imem_byte_loader #(
    parameter int ADDR_WIDTH  = 6,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int IW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            w_err_code_next;

    logic [7:0]            r_cnt_lo;
    logic [15:0]           r_n;
    logic [7:0]            r_chk;
    logic [1:0]            r_byte_idx;
    logic [15:0]           r_word_idx;
    logic [23:0]           r_word;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [1:0]            r_err_code;
    logic [IW-1:0]         r_idle;

    logic                  w_receiving;
    logic                  w_accept;
    logic                  w_start_ok;
    logic                  w_timeout;
    logic [15:0]           w_count;
    logic                  w_count_bad;
    logic                  w_last_word;

    // The four receive states are exactly the states that accept bytes.
    assign w_receiving = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) ||
                         (r_state == S_DATA)   || (r_state == S_CHK);
    assign w_accept    = rx_valid && w_receiving;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERR));
    // Idle counter has already counted TIMEOUT_CYC-1 empty cycles; one more
    // cycle without an accept is the timeout.
    assign w_timeout   = (r_idle == IW'(TIMEOUT_CYC - 1));
    assign w_count     = {rx_data, r_cnt_lo};
    assign w_count_bad = (w_count == 16'd0) || ({16'd0, w_count} > 32'(DEPTH));
    assign w_last_word = (r_word_idx == (r_n - 16'd1));

    assign rx_ready   = w_receiving;
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);
    assign cpu_hold   = (r_state != S_DONE);
    assign err_code   = r_err_code;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and error-code selection; an accept always beats the timeout.
    always_comb begin
        w_state_next    = r_state;
        w_err_code_next = r_err_code;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_next    = S_CNT_LO;
                    w_err_code_next = 2'b00;
                end
            end
            S_CNT_LO: begin
                if (w_accept) w_state_next = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (w_accept) begin
                    if (w_count_bad) begin
                        w_state_next    = S_ERR;
                        w_err_code_next = 2'b01;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && (r_byte_idx == 2'd3) && w_last_word) begin
                    w_state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    if (rx_data == r_chk) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next    = S_ERR;
                        w_err_code_next = 2'b10;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_receiving && !w_accept && w_timeout) begin
            w_state_next    = S_ERR;
            w_err_code_next = 2'b11;
        end
    end

    // Datapath: count capture, checksum, word assembly, write strobe, idle timer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt_lo   <= 8'd0;
            r_n        <= 16'd0;
            r_chk      <= 8'd0;
            r_byte_idx <= 2'd0;
            r_word_idx <= 16'd0;
            r_word     <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_err_code <= 2'b00;
            r_idle     <= '0;
        end else begin
            r_we       <= 1'b0;
            r_err_code <= w_err_code_next;
            if (w_start_ok) begin
                r_chk      <= 8'd0;
                r_byte_idx <= 2'd0;
                r_word_idx <= 16'd0;
                r_idle     <= '0;
            end else if (w_receiving) begin
                if (w_accept) begin
                    r_idle <= '0;
                    r_chk  <= r_chk ^ rx_data;
                    case (r_state)
                        S_CNT_LO: r_cnt_lo <= rx_data;
                        S_CNT_HI: r_n      <= w_count;
                        S_DATA: begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            // Shift in from the top so b0 ends in the low byte.
                            r_word     <= {rx_data, r_word[23:8]};
                            if (r_byte_idx == 2'd3) begin
                                r_we       <= 1'b1;
                                r_addr     <= r_word_idx[ADDR_WIDTH-1:0];
                                r_wdata    <= {rx_data, r_word};
                                r_word_idx <= r_word_idx + 16'd1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    r_idle <= r_idle + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_byte_loader.sv
// Testbench for imem_byte_loader: table of whole-frame loads plus directed
// sequences for timeout, threshold accept and asynchronous reset.
module tb_imem_byte_loader;

    localparam int AW = 6;
    localparam int TO = 20;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [1:0]    err_code;

    imem_byte_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST(RST), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .err_code(err_code)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    int            wc_q[$];

    // Record every write strobe seen mid-cycle.
    always @(negedge CLK) begin
        if (imem_we === 1'b1) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            wc_q.push_back(cyc);
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Present one byte and return at the negedge after it was accepted;
    // rx_valid is left high so consecutive calls stream without gaps.
    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && g < 50) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 50) begin
            n_total++;
            $display("FAIL rx_ready_wait: got 0, expected 1 within 50 cycles");
        end else begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    typedef struct packed {
        logic [15:0]       n;
        logic [2:0][31:0]  w;
        logic [7:0]        chk_flip;
        logic              exp_done;
        logic [1:0]        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic run_frame(input vec_t v, input int idx);
        logic [7:0] chk;
        logic [7:0] b;
        int ca, cb, nw, lim;
        pulse_start();
        clear_log();
        chk = v.n[7:0] ^ v.n[15:8];
        send_byte(v.n[7:0]);
        ca = cyc;
        send_byte(v.n[15:8]);
        if (v.exp_err != 2'b01) begin
            for (int i = 0; i < int'(v.n); i++) begin
                for (int k = 0; k < 4; k++) begin
                    b   = v.w[i][8*k +: 8];
                    chk = chk ^ b;
                    send_byte(b);
                end
            end
            check($sformatf("v%0d hold_before_chk", idx), {31'd0, cpu_hold}, 32'd1);
            send_byte(chk ^ v.chk_flip);
            cb = cyc;
            check($sformatf("v%0d hold_after_chk", idx), {31'd0, cpu_hold}, {31'd0, !v.exp_done});
            check($sformatf("v%0d stream_cycles", idx), cb - ca, 4 * int'(v.n) + 2);
        end
        rx_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check($sformatf("v%0d done", idx), {31'd0, done}, {31'd0, v.exp_done});
        check($sformatf("v%0d error", idx), {31'd0, error}, {31'd0, !v.exp_done});
        check($sformatf("v%0d err_code", idx), {30'd0, err_code}, {30'd0, v.exp_err});
        check($sformatf("v%0d cpu_hold", idx), {31'd0, cpu_hold}, {31'd0, !v.exp_done});
        check($sformatf("v%0d rx_ready", idx), {31'd0, rx_ready}, 32'd0);
        nw = (v.exp_err == 2'b01) ? 0 : int'(v.n);
        check($sformatf("v%0d write_count", idx), wa_q.size(), nw);
        lim = (wa_q.size() < nw) ? wa_q.size() : nw;
        for (int i = 0; i < lim; i++) begin
            check($sformatf("v%0d w%0d addr", idx, i), {{(32-AW){1'b0}}, wa_q[i]}, i);
            check($sformatf("v%0d w%0d data", idx, i), wd_q[i], v.w[i]);
            if (i > 0) check($sformatf("v%0d w%0d spacing", idx, i), wc_q[i] - wc_q[i-1], 4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        RST = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;

        vecs[0] = '0; vecs[0].n = 16'd2; vecs[0].w[0] = 32'h00500093;
        vecs[0].w[1] = 32'h00A00113; vecs[0].exp_done = 1'b1; vecs[0].exp_err = 2'b00;
        vecs[1] = '0; vecs[1].n = 16'd3; vecs[1].w[0] = 32'hDEADBEEF;
        vecs[1].w[1] = 32'h00000000; vecs[1].w[2] = 32'hFFFFFFFF;
        vecs[1].exp_done = 1'b1; vecs[1].exp_err = 2'b00;
        vecs[2] = '0; vecs[2].n = 16'd0; vecs[2].exp_err = 2'b01;
        vecs[3] = '0; vecs[3].n = 16'd65; vecs[3].exp_err = 2'b01;
        vecs[4] = '0; vecs[4].n = 16'd1; vecs[4].w[0] = 32'h12345678;
        vecs[4].chk_flip = 8'h01; vecs[4].exp_err = 2'b10;
        vecs[5] = '0; vecs[5].n = 16'd1; vecs[5].w[0] = 32'hCAFEF00D;
        vecs[5].exp_done = 1'b1; vecs[5].exp_err = 2'b00;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst imem_we", {31'd0, imem_we}, 32'd0);
        check("rst cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst error", {31'd0, error}, 32'd0);
        check("rst err_code", {30'd0, err_code}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle rx_ready", {31'd0, rx_ready}, 32'd0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // Timeout: three data bytes then silence
        pulse_start();
        clear_log();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        rx_valid = 1'b0;
        repeat (TO - 1) @(negedge CLK);
        check("to error_before", {31'd0, error}, 32'd0);
        @(negedge CLK);
        check("to error_at", {31'd0, error}, 32'd1);
        check("to err_code", {30'd0, err_code}, 32'd3);
        check("to cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("to rx_ready", {31'd0, rx_ready}, 32'd0);
        check("to writes", wa_q.size(), 0);

        // Byte delivered exactly in the threshold cycle is accepted
        pulse_start();
        clear_log();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
        rx_valid = 1'b0;
        repeat (TO - 1) @(negedge CLK);
        rx_data = 8'h12; rx_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rx_valid = 1'b0;
        check("thr error", {31'd0, error}, 32'd0);
        check("thr imem_we", {31'd0, imem_we}, 32'd1);
        check("thr wdata", imem_wdata, 32'h12345678);
        c = 8'h01 ^ 8'h00 ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12;
        send_byte(c);
        rx_valid = 1'b0;
        @(negedge CLK);
        check("thr done", {31'd0, done}, 32'd1);
        check("thr err_code", {30'd0, err_code}, 32'd0);

        // Asynchronous reset mid-DATA while the second write strobe is high
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0F); send_byte(8'h0F); send_byte(8'hA5); send_byte(8'hA5);
        check("ar pre_we", {31'd0, imem_we}, 32'd1);
        check("ar pre_addr", {{(32-AW){1'b0}}, imem_addr}, 32'd1);
        #2 RST = 1'b1;
        #1;
        check("ar imem_we", {31'd0, imem_we}, 32'd0);
        check("ar imem_addr", {{(32-AW){1'b0}}, imem_addr}, 32'd0);
        check("ar imem_wdata", imem_wdata, 32'd0);
        check("ar rx_ready", {31'd0, rx_ready}, 32'd0);
        check("ar cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("ar done", {31'd0, done}, 32'd0);
        check("ar error", {31'd0, error}, 32'd0);
        check("ar err_code", {30'd0, err_code}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("ar idle rx_ready", {31'd0, rx_ready}, 32'd0);
        check("ar idle cpu_hold", {31'd0, cpu_hold}, 32'd1);
        run_frame(vecs[5], 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_byte_loader.md
Name: imem_byte_loader

Overview:
- Runtime writer for the processor's 32-bit instruction memory; replaces file-based preload with a byte-stream loader.
- Accepts a framed byte stream on a valid/ready interface and assembles little-endian instruction words.
- Writes each word to the instruction memory write port and validates the frame with an XOR checksum.
- Holds the processor in reset until a load completes successfully.

Parameters:
- ADDR_WIDTH, 6, instruction memory word-address width; DEPTH = 2**ADDR_WIDTH words.
- TIMEOUT_CYC, 1000, maximum idle cycles between accepted bytes while receiving before abort.

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load in IDLE, DONE or ERR states; ignored in all other states.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address.
- imem_wdata  output  32  instruction word.
- cpu_hold  output  1  processor reset request; 1 = hold the core.
- done  output  1  level; last load succeeded.
- error  output  1  level; last load aborted.
- err_code  output  2  01 = bad count, 10 = checksum mismatch, 11 = timeout; 00 otherwise.

Behaviour:
- Frame format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4*N data bytes (b0 first, word = {b3,b2,b1,b0}), then 1 checksum byte.
- Checksum = XOR of all bytes from CNT_LO through the last data byte.
- Reset values: state = IDLE, rx_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_hold = 1, done = 0, error = 0, err_code = 00.
- Reset takes effect immediately and is asynchronous, including mid-load. A partial load leaves the memory contents undefined and cpu_hold = 1.
- States:
  - IDLE: on start -> CNT_LO; clears done, error, err_code; clears checksum accumulator, word index and byte index.
  - CNT_LO, CNT_HI, DATA, CHK: rx_ready = 1 in all four.
  - CNT_LO: on accept -> CNT_HI.
  - CNT_HI: on accept, evaluate N. If N == 0 or N > DEPTH -> ERR with code 01. Otherwise -> DATA.
  - DATA: byte index counts 0..3. On accepting byte index 3, the next cycle drives imem_we = 1 for exactly one cycle, with imem_addr = word index and imem_wdata = assembled word. The word index then increments.
  - DATA: the byte following byte index 3 may be accepted in the same cycle imem_we is high; there is no stall and no backpressure gap.
  - DATA: after word N-1 is assembled -> CHK.
  - CHK: on accept, compare the byte to the accumulator. Match -> DONE. Mismatch -> ERR with code 10.
  - DONE: done = 1, cpu_hold = 0, rx_ready = 0.
  - ERR: error = 1, cpu_hold = 1, rx_ready = 0; err_code holds its value until the next start.
- start in DONE or ERR: behaves as in IDLE and reasserts cpu_hold = 1 the next cycle.
- Timeout:
  - An idle counter runs in CNT_LO through CHK; it resets to 0 on every accepted byte.
  - When it reaches TIMEOUT_CYC -> ERR with code 11.
  - Words already written stay written.
- Simultaneous events: if an accept and the timeout threshold coincide, the accept wins. start in a receive state is ignored.
- imem_addr wraps: not applicable, because N <= DEPTH is enforced before any write.
- Bytes presented while rx_ready = 0 are not consumed.

Test Plan:
- Nominal load: start, stream N=2, words 0x00500093 and 0x00A00113, plus the correct checksum -> two imem_we pulses (addr 0 then 1, data as given); done = 1; cpu_hold falls one cycle after the checksum accept.
- Back-to-back bytes: rx_valid held high throughout a 3-word load -> no gaps in rx_ready; imem_we pulses exactly 4 cycles apart; done = 1.
- Bad count: N=0, then separately N=DEPTH+1 -> ERR; err_code = 01; no imem_we pulses; cpu_hold = 1.
- Checksum mismatch: valid N=1 frame with the checksum XOR 0x01 -> the word is written; error = 1; err_code = 10; cpu_hold = 1. A subsequent start with a correct frame -> done = 1, err_code = 00.
- Timeout: stop rx_valid after 3 data bytes for TIMEOUT_CYC cycles -> ERR with err_code = 11 exactly TIMEOUT_CYC cycles after the last accept. A byte delivered at the threshold cycle is accepted and no error is raised.
- Asynchronous reset mid-DATA: assert RST between clock edges -> all outputs at reset values immediately; after release the loader sits in IDLE until start.
